// File: rtl/tb_shield_uart_echo_if.sv
// Shield UART echo bus: per-channel serial lines plus receive status.
// The design takes the slave side; the bench drives the master side.
interface tb_shield_uart_echo_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]   RXD;
  logic [NUM_CH-1:0]   TXD;
  logic [NUM_CH-1:0]   ECHO_EN;
  logic [NUM_CH-1:0]   RX_VALID;
  logic [8*NUM_CH-1:0] RX_DATA;
  logic [NUM_CH-1:0]   OVERFLOW;
  logic [NUM_CH-1:0]   FRAME_ERR;

  modport master (
    output RXD, ECHO_EN,
    input  TXD, RX_VALID, RX_DATA, OVERFLOW, FRAME_ERR
  );

  modport slave (
    input  RXD, ECHO_EN,
    output TXD, RX_VALID, RX_DATA, OVERFLOW, FRAME_ERR
  );
endinterface

// File: rtl/tb_shield_uart_echo.sv
// N-channel 8N1 UART receiver with per-channel echo FIFO and transmitter.
// Optional stop-bit checking is enabled by defining TB_SHIELD_UART_FRAMING_CHECK_EN.
module tb_shield_uart_echo #(
  parameter int NUM_CH       = 2,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  tb_shield_uart_echo_if.slave uart
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic          rx_meta, rxs;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          stop_tick, stop_ok, rx_armed, accept;
    logic          ovf, ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          txd, tx_stop_end;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) {rx_meta, rxs} <= 2'b11;
      else         {rx_meta, rxs} <= {uart.RXD[c], rx_meta};
    end

    assign stop_tick = (rx_state == S_STOP) && (rx_cnt == BIT_END);

`ifdef TB_SHIELD_UART_FRAMING_CHECK_EN
    logic wait_high;

    assign stop_ok  = rxs;
    assign rx_armed = !wait_high;

    // After a bad stop bit the line must be seen high before a new start is trusted.
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        wait_high <= 1'b0;
        ferr      <= 1'b0;
      end else begin
        if (stop_tick && !rxs) begin
          wait_high <= 1'b1;
          ferr      <= 1'b1;
        end else if (rx_state == S_IDLE && rxs) begin
          wait_high <= 1'b0;
        end
      end
    end
`else
    assign stop_ok  = 1'b1;
    assign rx_armed = 1'b1;
    assign ferr     = 1'b0;
`endif

    assign accept = stop_tick && stop_ok;

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        rx_state <= S_IDLE;
        rx_cnt   <= '0;
        rx_bit   <= '0;
        rx_shift <= '0;
      end else begin
        case (rx_state)
          S_IDLE: begin
            rx_cnt <= '0;
            rx_bit <= '0;
            if (!rxs && rx_armed) rx_state <= S_START;
          end
          S_START: begin
            rx_cnt <= rx_cnt + CNT_ONE;
            if (rx_cnt == HALF_END) begin
              rx_cnt   <= '0;
              rx_state <= rxs ? S_IDLE : S_DATA;
            end
          end
          S_DATA: begin
            rx_cnt <= rx_cnt + CNT_ONE;
            if (rx_cnt == BIT_END) begin
              rx_cnt   <= '0;
              rx_shift <= {rxs, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
              if (rx_bit == 3'd7) rx_state <= S_STOP;
            end
          end
          default: begin
            rx_cnt <= rx_cnt + CNT_ONE;
            if (rx_cnt == BIT_END) rx_state <= S_IDLE;
          end
        endcase
      end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        rx_valid <= 1'b0;
        rx_data  <= '0;
        ovf      <= 1'b0;
      end else begin
        rx_valid <= accept;
        if (accept) rx_data <= rx_shift;
        if (accept && full && !pop) ovf <= 1'b1;
      end
    end

    // A push into a full FIFO succeeds only when the head leaves in the same cycle.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign push  = accept && (!full || pop);

    assign tx_stop_end = (tx_state == S_STOP) && (tx_cnt == BIT_END);
    assign pop = uart.ECHO_EN[c] && !empty && ((tx_state == S_IDLE) || tx_stop_end);

    always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr[AW-1:0]] <= rx_shift;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
    end

    // Popping at the end of the stop bit chains frames with no idle gap.
    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        tx_state <= S_IDLE;
        tx_cnt   <= '0;
        tx_bit   <= '0;
        tx_shift <= '0;
        txd      <= 1'b1;
      end else if (pop) begin
        tx_shift <= mem[rd_ptr[AW-1:0]];
        txd      <= 1'b0;
        tx_cnt   <= '0;
        tx_state <= S_START;
      end else begin
        case (tx_state)
          S_IDLE: begin
            txd    <= 1'b1;
            tx_cnt <= '0;
          end
          S_START: begin
            tx_cnt <= tx_cnt + CNT_ONE;
            if (tx_cnt == BIT_END) begin
              tx_cnt   <= '0;
              tx_bit   <= '0;
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_state <= S_DATA;
            end
          end
          S_DATA: begin
            tx_cnt <= tx_cnt + CNT_ONE;
            if (tx_cnt == BIT_END) begin
              tx_cnt <= '0;
              if (tx_bit == 3'd7) begin
                txd      <= 1'b1;
                tx_state <= S_STOP;
              end else begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
              end
            end
          end
          default: begin
            tx_cnt <= tx_cnt + CNT_ONE;
            if (tx_cnt == BIT_END) tx_state <= S_IDLE;
          end
        endcase
      end
    end

    assign uart.TXD[c]          = txd;
    assign uart.RX_VALID[c]     = rx_valid;
    assign uart.RX_DATA[8*c +: 8] = rx_data;
    assign uart.OVERFLOW[c]     = ovf;
    assign uart.FRAME_ERR[c]    = ferr;
  end
endmodule

// File: tb/tb_tb_shield_uart_echo.sv
// Self-checking bench for tb_shield_uart_echo: vector table, corner sequences and
// randomized rounds checked against a queue-based model of the echo behaviour.
module tb_tb_shield_uart_echo;
  localparam int NUM_CH = 2;
  localparam int CPB    = 16;
  localparam int DEPTH  = 4;
`ifdef TB_SHIELD_UART_FRAMING_CHECK_EN
  localparam bit FRAMING = 1'b1;
`else
  localparam bit FRAMING = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tb_shield_uart_echo_if #(.NUM_CH(NUM_CH)) uart ();

  tb_shield_uart_echo #(
    .NUM_CH      (NUM_CH),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK   (clk),
    .RESETn(rst_n),
    .uart  (uart)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    int          ch;
    logic [7:0]  data;
    logic        stop;
    logic [1:0]  echo;
    int          exp_valid;
    bit          exp_echo;
    bit          exp_ferr;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int          rx_cnt [NUM_CH];
  int unsigned rx_cyc [NUM_CH];
  int          rst_evt = 0;
  int          tx_bad  = 0;
  ev_t         tx_ev [$];
  int unsigned tx_t  [$];

  // Reference model state
  ev_t               exp_tx [$];
  logic [NUM_CH-1:0] m_echo;
  logic [7:0]        held [NUM_CH][DEPTH];
  int                held_n [NUM_CH];
  int                exp_rx_cnt [NUM_CH];
  logic [7:0]        exp_rx_data [NUM_CH];
  logic              exp_ovf [NUM_CH];
  logic              exp_ferr [NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_evt = rst_evt + 1;

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (uart.RX_VALID[c] === 1'b1) begin
        rx_cnt[c] = rx_cnt[c] + 1;
        rx_cyc[c] = cyc;
      end
    end
  end

  task automatic tx_decode(input int ch);
    int unsigned t0;
    int          r0;
    logic [7:0]  b;
    logic        ok;
    @(negedge clk);
    if (uart.TXD[ch] === 1'b0) begin
      t0 = cyc;
      r0 = rst_evt;
      ok = 1'b1;
      b  = '0;
      repeat (CPB/2) @(negedge clk);
      if (uart.TXD[ch] !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart.TXD[ch];
      end
      repeat (CPB) @(negedge clk);
      if (uart.TXD[ch] !== 1'b1) ok = 1'b0;
      if (r0 == rst_evt) begin
        if (ok) begin
          tx_ev.push_back('{ch, b});
          tx_t.push_back(t0);
        end else begin
          tx_bad = tx_bad + 1;
        end
      end
    end
  endtask

  initial forever tx_decode(0);
  initial forever tx_decode(1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [1:0] mask, input logic [7:0] d0,
                            input logic [7:0] d1, input logic stop);
    logic [9:0] f0, f1;
    f0 = {stop, d0, 1'b0};
    f1 = {stop, d1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart.RXD = {mask[1] ? f1[i] : 1'b1, mask[0] ? f0[i] : 1'b1};
      repeat (CPB-1) @(negedge clk);
    end
    @(negedge clk);
    uart.RXD = '1;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_echo(input logic [1:0] e);
    uart.ECHO_EN = e;
    m_echo       = e;
    for (int c = 0; c < NUM_CH; c++) begin
      if (e[c]) begin
        for (int i = 0; i < held_n[c]; i++) exp_tx.push_back('{c, held[c][i]});
        held_n[c] = 0;
      end
    end
  endtask

  // A byte goes straight out when echo is on (FIFO drains faster than RX fills),
  // otherwise it waits in a DEPTH-entry store and is lost once that is full.
  task automatic model_rx(input int ch, input logic [7:0] d, input logic stop);
    if (FRAMING && !stop) begin
      exp_ferr[ch] = 1'b1;
      return;
    end
    exp_rx_cnt[ch]++;
    exp_rx_data[ch] = d;
    if (m_echo[ch]) exp_tx.push_back('{ch, d});
    else if (held_n[ch] < DEPTH) begin
      held[ch][held_n[ch]] = d;
      held_n[ch]++;
    end else exp_ovf[ch] = 1'b1;
  endtask

  task automatic check_rx(input string name);
    logic [15:0] rd;
    rd = uart.RX_DATA;
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("%s ch%0d rx_valid count", name, c), rx_cnt[c], exp_rx_cnt[c]);
      check($sformatf("%s ch%0d rx_data", name, c), rd[8*c +: 8], exp_rx_data[c]);
      check($sformatf("%s ch%0d overflow", name, c), uart.OVERFLOW[c], exp_ovf[c]);
      check($sformatf("%s ch%0d frame_err", name, c), uart.FRAME_ERR[c], exp_ferr[c]);
    end
  endtask

  task automatic check_echo(input string name, input bit b2b);
    logic [7:0]  got [$];
    logic [7:0]  want [$];
    int unsigned t [$];
    for (int c = 0; c < NUM_CH; c++) begin
      got.delete(); want.delete(); t.delete();
      foreach (tx_ev[i]) if (tx_ev[i].ch == c) begin
        got.push_back(tx_ev[i].data);
        t.push_back(tx_t[i]);
      end
      foreach (exp_tx[i]) if (exp_tx[i].ch == c) want.push_back(exp_tx[i].data);
      check($sformatf("%s ch%0d echo count", name, c), got.size(), want.size());
      for (int i = 0; i < want.size() && i < got.size(); i++)
        check($sformatf("%s ch%0d echo byte %0d", name, c, i), got[i], want[i]);
      if (b2b)
        for (int i = 1; i < t.size(); i++)
          check($sformatf("%s ch%0d frame gap %0d", name, c, i), t[i] - t[i-1], 10*CPB);
    end
    tx_ev.delete();
    tx_t.delete();
    exp_tx.delete();
  endtask

  initial begin
    vec_t vecs [6];
    int   base;
    logic [15:0] rd;
    logic [1:0]  mask;
    int          k;
    logic [7:0]  d0, d1;

    vecs[0] = '{0, 8'hA5, 1'b1, 2'b01, 1, 1'b1, 1'b0};
    vecs[1] = '{1, 8'h5A, 1'b1, 2'b11, 1, 1'b1, 1'b0};
    vecs[2] = '{0, 8'h00, 1'b1, 2'b11, 1, 1'b1, 1'b0};
    vecs[3] = '{1, 8'hFF, 1'b1, 2'b10, 1, 1'b1, 1'b0};
    vecs[4] = '{0, 8'h81, 1'b1, 2'b01, 1, 1'b1, 1'b0};
    vecs[5] = '{0, 8'h55, 1'b0, 2'b01, FRAMING ? 0 : 1, !FRAMING, FRAMING};

    for (int c = 0; c < NUM_CH; c++) begin
      rx_cnt[c] = 0; held_n[c] = 0; exp_rx_cnt[c] = 0;
      exp_rx_data[c] = '0; exp_ovf[c] = 1'b0; exp_ferr[c] = 1'b0;
    end
    m_echo       = '0;
    uart.RXD     = '1;
    uart.ECHO_EN = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset txd", uart.TXD, 2'b11);
    check("reset rx_valid", uart.RX_VALID, 2'b00);
    check("reset rx_data", uart.RX_DATA, 16'h0000);
    check("reset overflow", uart.OVERFLOW, 2'b00);
    check("reset frame_err", uart.FRAME_ERR, 2'b00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single-frame vectors
    foreach (vecs[i]) begin
      set_echo(vecs[i].echo);
      base = rx_cnt[vecs[i].ch];
      send_frame(vecs[i].ch == 0 ? 2'b01 : 2'b10, vecs[i].data, vecs[i].data, vecs[i].stop);
      rd = uart.RX_DATA;
      check($sformatf("vec%0d rx pulses", i), rx_cnt[vecs[i].ch] - base, vecs[i].exp_valid);
      if (vecs[i].exp_valid != 0) begin
        check($sformatf("vec%0d rx_data", i), rd[8*vecs[i].ch +: 8], vecs[i].data);
        exp_rx_data[vecs[i].ch] = vecs[i].data;
      end
      check($sformatf("vec%0d frame_err", i), uart.FRAME_ERR[vecs[i].ch], vecs[i].exp_ferr);
      exp_rx_cnt[vecs[i].ch] += vecs[i].exp_valid;
      if (vecs[i].exp_ferr) exp_ferr[vecs[i].ch] = 1'b1;
      if (vecs[i].exp_echo) exp_tx.push_back('{vecs[i].ch, vecs[i].data});
      repeat (200) @(negedge clk);
      check_echo($sformatf("vec%0d", i), 1'b0);
      check($sformatf("vec%0d txd idle", i), uart.TXD, 2'b11);
    end
    check_rx("after vectors");

    // Short low pulse on ch0 must be rejected as a glitch
    set_echo(2'b11);
    @(negedge clk) uart.RXD = 2'b10;
    repeat (6) @(negedge clk);
    uart.RXD = 2'b11;
    repeat (200) @(negedge clk);
    check_rx("glitch");
    check_echo("glitch", 1'b0);
    check("glitch txd idle", uart.TXD, 2'b11);

    // Fill the ch0 FIFO with echo off, overflow on the fifth byte, then drain
    set_echo(2'b00);
    for (int i = 1; i <= 5; i++) begin
      send_frame(2'b01, 8'(i), 8'h00, 1'b1);
      model_rx(0, 8'(i), 1'b1);
      check($sformatf("fill byte %0d overflow", i), uart.OVERFLOW[0], exp_ovf[0]);
    end
    check("fill overflow set", uart.OVERFLOW[0], 1'b1);
    check_rx("fill");
    set_echo(2'b01);
    repeat (4*10*CPB + 60) @(negedge clk);
    check_echo("drain", 1'b1);

    // Both channels receive in the same frame time
    set_echo(2'b11);
    send_frame(2'b11, 8'h3C, 8'hC3, 1'b1);
    model_rx(0, 8'h3C, 1'b1);
    model_rx(1, 8'hC3, 1'b1);
    check("simul pulse cycle", rx_cyc[0], rx_cyc[1]);
    check("simul rx_data", uart.RX_DATA, 16'hC33C);
    check_rx("simul");
    repeat (200) @(negedge clk);
    check_echo("simul", 1'b0);

    // Randomized rounds: random echo mask, random byte bursts on both channels
    for (int r = 0; r < 8; r++) begin
      mask = 2'($urandom_range(0, 3));
      set_echo(mask);
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        send_frame(2'b11, d0, d1, 1'b1);
        model_rx(0, d0, 1'b1);
        model_rx(1, d1, 1'b1);
      end
      check_rx($sformatf("rand%0d", r));
      set_echo(2'b11);
      repeat (DEPTH*10*CPB + 250) @(negedge clk);
      check_echo($sformatf("rand%0d", r), 1'b0);
    end

    // Reset in the middle of an echo frame with bytes still queued
    set_echo(2'b00);
    for (int i = 0; i < 3; i++) begin
      send_frame(2'b01, 8'hE0 + 8'(i), 8'h00, 1'b1);
      model_rx(0, 8'hE0 + 8'(i), 1'b1);
    end
    uart.ECHO_EN = 2'b01;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset txd", uart.TXD, 2'b11);
    check("midreset overflow", uart.OVERFLOW, 2'b00);
    check("midreset frame_err", uart.FRAME_ERR, 2'b00);
    check("midreset rx_data", uart.RX_DATA, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      held_n[c] = 0; exp_ovf[c] = 1'b0; exp_ferr[c] = 1'b0; exp_rx_data[c] = '0;
    end
    exp_tx.delete();
    m_echo = 2'b01;
    repeat (700) @(negedge clk);
    check_echo("post reset quiet", 1'b0);
    send_frame(2'b01, 8'h96, 8'h00, 1'b1);
    model_rx(0, 8'h96, 1'b1);
    repeat (200) @(negedge clk);
    check_echo("post reset echo", 1'b0);
    check_rx("post reset");
    check("malformed tx frames", tx_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tb_shield_uart_echo.md
# tb_shield_uart_echo

Parametrised multi-channel UART echo model for the Arduino-shield testbench. It attaches to the shield UART lines that the adaptor routes from the EXP header and deserialises 8N1 frames on each channel. Received bytes are exposed to the bench and buffered in a per-channel FIFO, and can be re-transmitted (echoed) back to the DUT. It replaces the fixed, two-shield passive UART hookup with an N-channel active responder, so loopback software tests need no external model.

## Interface
- NUM_CH, 2, number of independent UART channels (1..4).
- CLKS_PER_BIT, 16, CLK cycles per bit. Must be even and ≥ 4.
- FIFO_DEPTH, 4, echo FIFO entries per channel. Power of two, 2..16.

- CLK  input  1  bench clock.
- RESETn  input  1  reset. One clock; reset is asynchronous and active-low.
- RXD  input  NUM_CH  serial data from DUT, one bit per channel. Idle high.
- TXD  output  NUM_CH  echoed serial data to DUT. Reset 1 (idle).
- ECHO_EN  input  NUM_CH  per-channel echo enable.
- RX_VALID  output  NUM_CH  one-cycle pulse per accepted byte. Reset 0.
- RX_DATA  output  8*NUM_CH  last accepted byte; channel n occupies [8n+7:8n]. Reset 0x00.
- OVERFLOW  output  NUM_CH  sticky; set when a byte is dropped because the FIFO is full. Reset 0.
- FRAME_ERR  output  NUM_CH  sticky framing error. Reset 0. Tied 0 when the macro is absent.

## Operation
- Channels are fully independent. The description below applies to each channel.
- RXD passes through a 2-flop synchroniser, called rxs below.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rxs==0, go to START and clear the bit counter.
  - START: at CLKS_PER_BIT/2 cycles, sample rxs. If it is 1, treat it as a glitch and return to IDLE. If it is 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first. Then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If the stop bit is 1: accept the byte, then return to IDLE.
    - If the stop bit is 0: see Configuration, then return to IDLE.
- On accept:
  - Update RX_DATA.
  - Pulse RX_VALID.
  - Push the byte to the FIFO. If the FIFO is full, drop the byte and set OVERFLOW.
- TX FSM states: IDLE, START, DATA, STOP. Each bit lasts CLKS_PER_BIT cycles.
  - In IDLE, when ECHO_EN=1 and the FIFO is non-empty, pop the head and drive the start bit (0).
  - Then drive 8 data bits LSB first, then the stop bit (1), then return to IDLE.
- If ECHO_EN falls mid-frame, the current frame completes and no further pop occurs.
- FIFO pointers carry an extra wrap bit: full when the addresses match and the wrap bits differ; empty when the pointers are equal.
- Push and pop in the same cycle while full: both succeed, there is no overflow and the occupancy is unchanged.
- Push and pop in the same cycle while empty: not possible, because a pop requires non-empty in the prior cycle.
- ECHO_EN=0: bytes accumulate in the FIFO. Once full, each new byte sets OVERFLOW.

## Timing
- Falling edge on RXD to START entry: 2 CLK cycles (synchroniser).
- Stop-bit sample instant to RX_VALID high: 1 cycle. RX_DATA is valid in the same cycle and holds until the next accept.
- Byte visible in the FIFO to TXD start-bit low: 1 cycle, when TX is idle and ECHO_EN=1.
- Frame length: 10*CLKS_PER_BIT cycles.
- Back-to-back TX frames follow with zero idle cycles.
- Reset asserted mid-frame:
  - TXD returns to 1 asynchronously.
  - FIFO is emptied and both FSMs go to IDLE.
  - OVERFLOW and FRAME_ERR clear.
  - After release, a partial RX frame in progress is seen as line noise until the next start bit.

## Configuration
- TB_SHIELD_UART_FRAMING_CHECK_EN defined:
  - A stop bit sampled 0 sets FRAME_ERR.
  - The byte is discarded: no RX_VALID and no push.
  - The RX FSM waits in IDLE until rxs==1 before accepting a new start bit.
- Undefined:
  - The stop bit is ignored and the byte is accepted as normal.
  - FRAME_ERR is constant 0.

## Test plan
- NUM_CH=2, CLKS_PER_BIT=16, ECHO_EN=2'b01. Send 0xA5 on RXD[0]. Required: RX_VALID[0] pulses once, RX_DATA[7:0]=0xA5, TXD[0] echoes 0xA5 framed 0-10100101(LSB first)-1. TXD[1] stays 1.
- RXD[0] low pulse of 6 cycles. Required: glitch rejected, no RX_VALID, TXD[0] idle.
- ECHO_EN=0, FIFO_DEPTH=4. Send 5 bytes 0x01..0x05. Required: 5 RX_VALID pulses, OVERFLOW[0]=1 after the 5th byte. Then set ECHO_EN=1: TXD[0] emits exactly 0x01..0x04 back-to-back over 640 cycles.
- Both channels receive simultaneously (0x3C on ch0, 0xC3 on ch1). Required: independent RX_VALID pulses in the same cycle, RX_DATA=0xC33C.
- With the macro defined, send 0x55 with stop bit 0. Required: FRAME_ERR[0]=1, no RX_VALID, no echo. Without the macro: 0x55 is accepted and echoed.
- Assert RESETn mid-TX frame. Required: TXD=all 1s immediately, FIFO empty, no transmission after release until a new byte is received.
